mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the two cache masters, the memory slave and mem_arbiter.
// The arbiter uses the slave modport; the surrounding environment uses master.
interface mem_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [3:0]  m0_be;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m0_rdata;
  logic        m0_rvalid;
  logic        m0_fault;

  logic        m1_req;
  logic        m1_we;
  logic [3:0]  m1_be;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [31:0] m1_rdata;
  logic        m1_rvalid;
  logic        m1_fault;

  logic        s_req;
  logic        s_we;
  logic [3:0]  s_be;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        s_rvalid;
  logic        s_fault;

  logic        proto_err;

  modport slave (
    input  m0_req, m0_we, m0_be, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_be, m1_addr, m1_wdata,
    input  s_ready, s_rdata, s_rvalid, s_fault,
    output m0_rdata, m0_rvalid, m0_fault,
    output m1_rdata, m1_rvalid, m1_fault,
    output s_req, s_we, s_be, s_addr, s_wdata,
    output proto_err
  );

  modport master (
    output m0_req, m0_we, m0_be, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_be, m1_addr, m1_wdata,
    output s_ready, s_rdata, s_rvalid, s_fault,
    input  m0_rdata, m0_rvalid, m0_fault,
    input  m1_rdata, m1_rvalid, m1_fault,
    input  s_req, s_we, s_be, s_addr, s_wdata,
    input  proto_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for two single-outstanding masters onto one slave; req->s_req takes 2 cycles.
// s_req holds until s_ready; responses route combinationally; a silent slave is faulted after TIMEOUT_CYCLES.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam int            CW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] T_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit            TMO_EN = (TIMEOUT_CYCLES > 0);

  logic [1:0]    state;
  logic          owner;
  logic          last_grant;
  logic [CW-1:0] tcnt;

  logic [1:0]    slot_vld;
  logic [1:0]    slot_we;
  logic [3:0]    slot_be    [2];
  logic [31:0]   slot_addr  [2];
  logic [31:0]   slot_wdata [2];

  logic [1:0]    req;
  logic [1:0]    req_we;
  logic [3:0]    req_be    [2];
  logic [31:0]   req_addr  [2];
  logic [31:0]   req_wdata [2];
  logic [1:0]    busy;
  logic [1:0]    drop;
  logic [1:0]    take;
  logic          rsp;
  logic          tmo;
  logic          hs;
  logic          winner;

  always_comb begin
    req          = {bus.m1_req, bus.m0_req};
    req_we       = {bus.m1_we, bus.m0_we};
    req_be[0]    = bus.m0_be;
    req_be[1]    = bus.m1_be;
    req_addr[0]  = bus.m0_addr;
    req_addr[1]  = bus.m1_addr;
    req_wdata[0] = bus.m0_wdata;
    req_wdata[1] = bus.m1_wdata;
    // A master is busy from capture until the edge that ends its response cycle.
    busy[0] = slot_vld[0] | ((state != IDLE) && !owner);
    busy[1] = slot_vld[1] | ((state != IDLE) && owner);
    drop    = req & busy;
    take    = req & ~busy;
    hs      = (state == ISSUE) && bus.s_ready;
    rsp     = (state == WAIT) && (bus.s_rvalid || bus.s_fault);
    tmo     = (state == WAIT) && !rsp && TMO_EN && (tcnt == T_LAST);
    winner  = (&slot_vld) ? ~last_grant : slot_vld[1];
  end

  always_comb begin
    bus.s_req   = (state == ISSUE);
    bus.s_we    = 1'b0;
    bus.s_be    = '0;
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    if (state == ISSUE) begin
      bus.s_we    = slot_we[owner];
      bus.s_be    = slot_be[owner];
      bus.s_addr  = slot_addr[owner];
      bus.s_wdata = slot_wdata[owner];
    end
    bus.m0_rvalid = rsp && !owner && bus.s_rvalid;
    bus.m0_rdata  = (rsp && !owner) ? bus.s_rdata : '0;
    bus.m0_fault  = !owner && ((rsp && bus.s_fault) || tmo);
    bus.m1_rvalid = rsp && owner && bus.s_rvalid;
    bus.m1_rdata  = (rsp && owner) ? bus.s_rdata : '0;
    bus.m1_fault  = owner && ((rsp && bus.s_fault) || tmo);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= 1'b0;
      last_grant    <= 1'b1;
      tcnt          <= '0;
      slot_vld      <= '0;
      slot_we       <= '0;
      bus.proto_err <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        slot_be[i]    <= '0;
        slot_addr[i]  <= '0;
        slot_wdata[i] <= '0;
      end
    end else begin
      bus.proto_err <= |drop;
      for (int i = 0; i < 2; i++) begin
        if (take[i]) begin
          slot_vld[i]   <= 1'b1;
          slot_we[i]    <= req_we[i];
          slot_be[i]    <= req_be[i];
          slot_addr[i]  <= req_addr[i];
          slot_wdata[i] <= req_wdata[i];
        end else if (hs && (owner == 1'(i))) begin
          slot_vld[i] <= 1'b0;
        end
      end
      case (state)
        IDLE: begin
          if (|slot_vld) begin
            owner <= winner;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.s_ready) begin
            last_grant <= owner;
            tcnt       <= '0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (rsp || tmo) state <= IDLE;
          else            tcnt  <= tcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector table plus randomized traffic checked against a transaction-level model of mem_arbiter.
module tb_mem_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if bus();
  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, int idx, logic [68:0] act, logic [68:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  typedef struct {
    bit          rst, m0r, m1r, rdy, rv;
    logic [31:0] rd;
    int          own;   // 0 none, 1 m0 issuing, 2 m1 issuing
    int          rsp;   // 0 none, 1 m0 rvalid, 2 m1 rvalid, 3 m0 fault, 4 m1 fault
    bit          perr;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } pay_t;

  function automatic vec_t v(bit rst, bit m0r, bit m1r, bit rdy, bit rv,
                             logic [31:0] rd, int own, int rsp, bit perr);
    vec_t r;
    r.rst = rst; r.m0r = m0r; r.m1r = m1r; r.rdy = rdy; r.rv = rv;
    r.rd = rd; r.own = own; r.rsp = rsp; r.perr = perr;
    return r;
  endfunction

  localparam pay_t P0 = '{we: 1'b0, be: 4'hF, addr: 32'h0000_0100, wdata: 32'h0};
  localparam pay_t P1 = '{we: 1'b1, be: 4'h3, addr: 32'h0000_0200, wdata: 32'h0000_1234};

  vec_t tbl[$];

  // Model state for the randomized section
  bit   busy [2];
  bit   pend [2];
  pay_t pq   [2];
  int   pend_since [2];
  bit   outst;
  int   out_id, wait_k, out_d;
  bit   last_drop;
  int   last_iss;
  bit   prev_sreq;
  int   n_capt, n_done;

  initial begin
    rst_n = 1'b0;
    bus.m0_req = 0; bus.m1_req = 0;
    {bus.m0_we, bus.m0_be, bus.m0_addr, bus.m0_wdata} = P0;
    {bus.m1_we, bus.m1_be, bus.m1_addr, bus.m1_wdata} = P1;
    bus.s_ready = 0; bus.s_rvalid = 0; bus.s_fault = 0; bus.s_rdata = '0;

    // single m0 read
    tbl.push_back(v(1,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,1,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1,32'hDEADBEEF,0,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0));
    // round-robin: two simultaneous pairs
    tbl.push_back(v(1,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,1,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,1,32'hA1A1_0001,0,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,1,0,0,2,0,0));
    tbl.push_back(v(0,0,0,0,1,32'hB2B2_0002,0,2,0));
    tbl.push_back(v(0,1,1,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,1,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,1,32'hC3C3_0003,0,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,1,0,0,2,0,0));
    tbl.push_back(v(0,0,0,0,1,32'hD4D4_0004,0,2,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0));
    // m1 write stalled by s_ready low for 4 cycles
    tbl.push_back(v(0,0,1,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0));
    for (int k = 0; k < 4; k++) tbl.push_back(v(0,0,0,0,0,0,2,0,0));
    tbl.push_back(v(0,0,0,1,0,0,2,0,0));
    tbl.push_back(v(0,0,0,0,1,32'hCAFE_0001,0,2,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0));
    // m0 re-requests while its read is outstanding
    tbl.push_back(v(0,1,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,1,0,0,1,0,0));
    tbl.push_back(v(0,1,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1));
    tbl.push_back(v(0,1,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1));
    tbl.push_back(v(0,0,0,0,1,32'h0000_0055,0,1,0));
    tbl.push_back(v(0,0,0,1,0,0,0,0,0));
    tbl.push_back(v(0,0,0,1,0,0,0,0,0));
    // timeout on the 8th WAIT cycle, late response ignored
    tbl.push_back(v(0,1,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,1,0,0,1,0,0));
    for (int k = 0; k < TO - 1; k++) tbl.push_back(v(0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,3,0));
    tbl.push_back(v(0,0,0,0,1,32'h0000_0099,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0));
    // reset during WAIT, slave answers afterwards
    tbl.push_back(v(0,0,1,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,1,0,0,2,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,1,32'h0000_0077,0,0,0));
    tbl.push_back(v(0,0,0,0,1,32'h0000_0088,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0));

    repeat (2) @(negedge clk);

    foreach (tbl[i]) begin
      pay_t ep;
      @(negedge clk);
      rst_n        = !tbl[i].rst;
      bus.m0_req   = tbl[i].m0r;
      bus.m1_req   = tbl[i].m1r;
      bus.s_ready  = tbl[i].rdy;
      bus.s_rvalid = tbl[i].rv;
      bus.s_fault  = 1'b0;
      bus.s_rdata  = tbl[i].rd;
      #1;
      ep = (tbl[i].own == 1) ? P0 : (tbl[i].own == 2) ? P1 : '0;
      chk("s_req", i, bus.s_req, tbl[i].own != 0);
      chk("s_fields", i, {bus.s_we, bus.s_be, bus.s_addr, bus.s_wdata}, ep);
      chk("m0_rvalid", i, bus.m0_rvalid, tbl[i].rsp == 1);
      chk("m1_rvalid", i, bus.m1_rvalid, tbl[i].rsp == 2);
      chk("m0_fault", i, bus.m0_fault, tbl[i].rsp == 3);
      chk("m1_fault", i, bus.m1_fault, tbl[i].rsp == 4);
      chk("m0_rdata", i, bus.m0_rdata, (tbl[i].rsp == 1) ? tbl[i].rd : 32'h0);
      chk("m1_rdata", i, bus.m1_rdata, (tbl[i].rsp == 2) ? tbl[i].rd : 32'h0);
      chk("proto_err", i, bus.proto_err, tbl[i].perr);
    end

    // Randomized traffic against a transaction-level model
    @(negedge clk);
    rst_n = 1'b0;
    bus.m0_req = 0; bus.m1_req = 0; bus.s_rvalid = 0; bus.s_fault = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int x = 0; x < 2; x++) begin
      busy[x] = 0; pend[x] = 0; pq[x] = '0; pend_since[x] = 0;
    end
    outst = 0; out_id = 0; wait_k = 0; out_d = 0; last_drop = 0;
    last_iss = 1; prev_sreq = 0; n_capt = 0; n_done = 0;

    for (int cyc = 0; cyc < 4040; cyc++) begin
      bit          quiet, resp_now, tmo_now, d0, d1;
      logic [31:0] tmp;
      logic        e_rv [2];
      logic        e_f  [2];
      logic [31:0] e_rd [2];
      int          id, kind;

      @(negedge clk);
      quiet = (cyc >= 4000);
      bus.m0_req = !quiet && ($urandom % 5 == 0);
      bus.m1_req = !quiet && ($urandom % 5 == 0);
      tmp = $urandom; bus.m0_addr = {1'b0, tmp[30:0]};
      tmp = $urandom; bus.m1_addr = {1'b1, tmp[30:0]};
      bus.m0_we = 1'($urandom); bus.m1_we = 1'($urandom);
      bus.m0_be = 4'($urandom); bus.m1_be = 4'($urandom);
      bus.m0_wdata = $urandom;  bus.m1_wdata = $urandom;
      bus.s_ready = 1'($urandom);
      resp_now = outst && (out_d <= TO) && (wait_k == out_d);
      tmo_now  = outst && (out_d > TO) && (wait_k == TO);
      if (resp_now || (!outst && ($urandom % 10 == 0))) begin
        kind = int'($urandom % 4);
        bus.s_rvalid = (kind != 0);
        bus.s_fault  = (kind == 0) || (kind == 3);
        bus.s_rdata  = $urandom;
      end else begin
        bus.s_rvalid = 0; bus.s_fault = 0; bus.s_rdata = '0;
      end
      #1;

      for (int x = 0; x < 2; x++) begin
        e_rv[x] = 0; e_f[x] = 0; e_rd[x] = '0;
      end
      if (resp_now) begin
        e_rv[out_id] = bus.s_rvalid;
        e_f[out_id]  = bus.s_fault;
        e_rd[out_id] = bus.s_rdata;
      end
      if (tmo_now) e_f[out_id] = 1'b1;
      chk("rnd_m0_rsp", cyc, {bus.m0_rvalid, bus.m0_fault, bus.m0_rdata}, {e_rv[0], e_f[0], e_rd[0]});
      chk("rnd_m1_rsp", cyc, {bus.m1_rvalid, bus.m1_fault, bus.m1_rdata}, {e_rv[1], e_f[1], e_rd[1]});
      chk("rnd_proto_err", cyc, bus.proto_err, last_drop);

      id = bus.s_addr[31] ? 1 : 0;
      if (bus.s_req) begin
        chk("rnd_issue_pending", cyc, pend[id], 1'b1);
        chk("rnd_issue_while_busy", cyc, outst, 1'b0);
        chk("rnd_issue_fields", cyc, {bus.s_we, bus.s_be, bus.s_addr, bus.s_wdata}, pq[id]);
        if (!prev_sreq && pend[1-id] && pend_since[1-id] <= cyc - 2 && pend_since[id] <= cyc - 2)
          chk("rnd_rr_order", cyc, id, 1 - last_iss);
      end else begin
        chk("rnd_s_idle_zero", cyc, {bus.s_we, bus.s_be, bus.s_addr, bus.s_wdata}, '0);
      end

      d0 = bus.m0_req && busy[0];
      d1 = bus.m1_req && busy[1];
      if (resp_now || tmo_now) begin
        outst = 0;
        busy[out_id] = 0;
        n_done++;
      end
      if (bus.m0_req && !d0) begin
        busy[0] = 1; pend[0] = 1; pend_since[0] = cyc; n_capt++;
        pq[0] = {bus.m0_we, bus.m0_be, bus.m0_addr, bus.m0_wdata};
      end
      if (bus.m1_req && !d1) begin
        busy[1] = 1; pend[1] = 1; pend_since[1] = cyc; n_capt++;
        pq[1] = {bus.m1_we, bus.m1_be, bus.m1_addr, bus.m1_wdata};
      end
      if (outst) wait_k++;
      if (bus.s_req && bus.s_ready) begin
        pend[id] = 0;
        outst    = 1;
        out_id   = id;
        wait_k   = 1;
        out_d    = int'($urandom_range(1, TO + 3));
        last_iss = id;
      end
      last_drop = d0 || d1;
      prev_sreq = bus.s_req;
    end

    chk("drain_m0_pending", 0, pend[0], 1'b0);
    chk("drain_m1_pending", 0, pend[1], 1'b0);
    chk("drain_outstanding", 0, outst, 1'b0);
    chk("all_served", 0, n_done, n_capt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
